fclass_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-precision FPU classifier.
- Classifies single- or double-precision operands into the 10-bit class mask, including NaN-boxing checks on single operands held in a 64-bit register file.
- Sits in the FPU misc-op path between operand read and write-back.
- Two-stage elastic pipeline with valid/ready handshake, tag passthrough and flush.

---
 rtl/fclass_pkg.sv | 28 ++
 rtl/fclass_decode.sv | 24 ++
 rtl/fclass_pipe.sv | 76 +++++++
 tb/tb_fclass_pipe.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fclass_pkg.sv
// fclass_pkg: shared class indices, format codes, field widths and decode flags for fclass_pipe.
package fclass_pkg;
    localparam logic [3:0] CLS_NINF  = 4'd0;
    localparam logic [3:0] CLS_NNORM = 4'd1;
    localparam logic [3:0] CLS_NSUB  = 4'd2;
    localparam logic [3:0] CLS_NZERO = 4'd3;
    localparam logic [3:0] CLS_PZERO = 4'd4;
    localparam logic [3:0] CLS_PSUB  = 4'd5;
    localparam logic [3:0] CLS_PNORM = 4'd6;
    localparam logic [3:0] CLS_PINF  = 4'd7;
    localparam logic [3:0] CLS_SNAN  = 4'd8;
    localparam logic [3:0] CLS_QNAN  = 4'd9;
    localparam logic FMT_S = 1'b0;
    localparam logic FMT_D = 1'b1;
    localparam int EXP_W_S = 8;
    localparam int MAN_W_S = 23;
    localparam int EXP_W_D = 11;
    localparam int MAN_W_D = 52;
    localparam logic [31:0] BOX_PAT = 32'hFFFF_FFFF;
    typedef struct packed {
        logic sign;
        logic exp_zero;
        logic exp_ones;
        logic frac_zero;
        logic frac_msb;
        logic box_fail;
    } flags_t;
endpackage

// File: rtl/fclass_decode.sv
// fclass_decode: combinational field decode and NaN-box check of one operand.
module fclass_decode
    import fclass_pkg::*;
#(
    parameter int FLEN = 64
) (
    input  logic            fmt,
    input  logic [FLEN-1:0] opnd,
    output flags_t          flags
);
    logic [63:0] x;
    logic dbl;
    assign x = 64'(opnd);
    assign dbl = (FLEN == 64) && (fmt == FMT_D);
    always_comb begin
        flags.sign      = dbl ? x[EXP_W_D+MAN_W_D] : x[EXP_W_S+MAN_W_S];
        flags.exp_zero  = dbl ? (x[EXP_W_D+MAN_W_D-1:MAN_W_D] == '0) : (x[EXP_W_S+MAN_W_S-1:MAN_W_S] == '0);
        flags.exp_ones  = dbl ? (&x[EXP_W_D+MAN_W_D-1:MAN_W_D]) : (&x[EXP_W_S+MAN_W_S-1:MAN_W_S]);
        flags.frac_zero = dbl ? (x[MAN_W_D-1:0] == '0) : (x[MAN_W_S-1:0] == '0);
        flags.frac_msb  = dbl ? x[MAN_W_D-1] : x[MAN_W_S-1];
        // single operands in a 64-bit file must be NaN-boxed
        flags.box_fail  = (FLEN == 64) && !dbl && (x[63:32] != BOX_PAT);
    end
endmodule

// File: rtl/fclass_pipe.sv
// fclass_pipe: two-stage elastic FP classifier producing the 10-bit one-hot class mask.
module fclass_pipe
    import fclass_pkg::*;
#(
    parameter int FLEN  = 64,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             i_fmt,
    input  logic [FLEN-1:0]  i_opnd,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             flush,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [XLEN-1:0]  o_res,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_snan
);
    flags_t d_flags, s1_flags;
    logic s1_valid, s2_valid, s1_adv, s2_adv;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [9:0] s2_res, cls;
    logic [3:0] idx;
    fclass_decode #(.FLEN(FLEN)) dec (.fmt(i_fmt), .opnd(i_opnd), .flags(d_flags));
    assign s2_adv  = !s2_valid || o_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign i_ready = s1_adv;
    // a result still showing in the flush cycle belongs to a killed op
    assign o_valid = s2_valid && !flush;
    assign o_res   = XLEN'(s2_res);
    assign o_tag   = s2_tag;
    assign o_snan  = s2_res[CLS_SNAN];
    always_comb begin
        idx = s1_flags.box_fail ? CLS_QNAN
            : s1_flags.exp_ones ? (s1_flags.frac_zero ? (s1_flags.sign ? CLS_NINF : CLS_PINF)
                                                      : (s1_flags.frac_msb ? CLS_QNAN : CLS_SNAN))
            : s1_flags.exp_zero ? (s1_flags.frac_zero ? (s1_flags.sign ? CLS_NZERO : CLS_PZERO)
                                                      : (s1_flags.sign ? CLS_NSUB : CLS_PSUB))
            : (s1_flags.sign ? CLS_NNORM : CLS_PNORM);
        cls = 10'd1 << idx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_flags <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_flags <= d_flags;
                s1_tag   <= i_tag;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_tag   <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= cls;
                s2_tag <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_fclass_pipe.sv
// tb_fclass_pipe: vector table, handshake/flush/reset sequences and randomized scoreboard for fclass_pipe.
module tb_fclass_pipe;
    logic clk = 1'b0, rst = 1'b1;
    logic i_valid = 1'b0, i_fmt = 1'b0, flush = 1'b0, o_ready = 1'b1;
    logic i_ready, o_valid, o_snan;
    logic [63:0] i_opnd = '0;
    logic [4:0] i_tag = '0, o_tag;
    logic [31:0] o_res;
    fclass_pipe #(.FLEN(64), .XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_fmt(i_fmt),
        .i_opnd(i_opnd), .i_tag(i_tag), .flush(flush), .o_valid(o_valid), .o_ready(o_ready),
        .o_res(o_res), .o_tag(o_tag), .o_snan(o_snan)
    );
    always #5 clk = ~clk;
    typedef struct { logic fmt; logic [63:0] opnd; logic [31:0] res; } vec_t;
    typedef struct { logic [9:0] res; logic [4:0] tag; } exp_t;
    vec_t tbl[15];
    exp_t q[$];
    int tests = 0, fails = 0;
    logic prev_stall = 1'b0, prev_fl = 1'b0, last_acc, last_out, last_irdy;
    logic [31:0] held_res;
    logic [4:0] held_tag;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    // classification straight from the IEEE-754 field rules
    function automatic logic [9:0] model(input logic fmt, input logic [63:0] x);
        int ew = fmt ? 11 : 8;
        int mw = fmt ? 52 : 23;
        longint unsigned v, e, f, emax, s;
        int idx;
        if (!fmt && x[63:32] != 32'hFFFF_FFFF) return 10'h200;
        v = fmt ? x : {32'd0, x[31:0]};
        s = (v >> (ew + mw)) & 64'd1;
        emax = (64'd1 << ew) - 64'd1;
        e = (v >> mw) & emax;
        f = v & ((64'd1 << mw) - 64'd1);
        if (e == emax) idx = (f == 0) ? (s != 0 ? 0 : 7) : (((f >> (mw - 1)) != 0) ? 9 : 8);
        else if (e == 0) idx = (f == 0) ? (s != 0 ? 3 : 4) : (s != 0 ? 2 : 5);
        else idx = (s != 0) ? 1 : 6;
        return 10'd1 << idx;
    endfunction
    function automatic logic [63:0] rnd_op(input logic fmt);
        int ew = fmt ? 11 : 8;
        int mw = fmt ? 52 : 23;
        longint unsigned emax, e, f, v;
        int pe = $urandom % 4;
        int pf = $urandom % 3;
        emax = (64'd1 << ew) - 64'd1;
        e = (pe == 0) ? 64'd0 : (pe == 1) ? emax : longint'($urandom) % (emax + 64'd1);
        f = (pf == 0) ? 64'd0 : (pf == 1) ? (64'd1 << (mw - 1)) : ({$urandom, $urandom} & ((64'd1 << mw) - 64'd1));
        v = (longint'($urandom % 2) << (ew + mw)) | (e << mw) | f;
        if (!fmt) v = {(($urandom % 8) == 0) ? 32'($urandom) : 32'hFFFF_FFFF, v[31:0]};
        return v;
    endfunction
    task automatic cyc(input logic v, input logic fmt, input logic [63:0] op, input logic [4:0] tag,
                       input logic ordy, input logic fl);
        exp_t e;
        i_valid = v; i_fmt = fmt; i_opnd = op; i_tag = tag; o_ready = ordy; flush = fl;
        #1;
        last_irdy = i_ready;
        if (prev_stall && !prev_fl && !fl) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_res", o_res, held_res);
            chk("stall_tag", o_tag, held_tag);
        end
        last_out = o_valid && o_ready;
        if (last_out) begin
            if (q.size() == 0) chk("unexpected_out", o_valid, 0);
            else begin
                e = q.pop_front();
                chk("sb_res", o_res, 32'(e.res));
                chk("sb_tag", o_tag, e.tag);
                chk("sb_snan", o_snan, e.res[8]);
            end
        end
        if (fl) chk("flush_out", o_valid, 0);
        last_acc = v && i_ready && !fl;
        if (last_acc) q.push_back('{model(fmt, op), tag});
        if (fl) q.delete();
        prev_stall = o_valid && !o_ready; prev_fl = fl; held_res = o_res; held_tag = o_tag;
        @(posedge clk); #1;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        int t, acc, outs, first_k, last_k;
        tbl[0]  = '{1'b0, 64'hFFFFFFFF_3F800000, 32'h040};
        tbl[1]  = '{1'b0, 64'hFFFFFFFF_80000000, 32'h008};
        tbl[2]  = '{1'b0, 64'hFFFFFFFF_7FA00000, 32'h100};
        tbl[3]  = '{1'b0, 64'h00000000_3F800000, 32'h200};
        tbl[4]  = '{1'b1, 64'hFFF0000000000000, 32'h001};
        tbl[5]  = '{1'b1, 64'h0000000000000001, 32'h020};
        tbl[6]  = '{1'b1, 64'h7FF8000000000000, 32'h200};
        tbl[7]  = '{1'b1, 64'h8000000000000000, 32'h008};
        tbl[8]  = '{1'b0, 64'hFFFFFFFF_7F800000, 32'h080};
        tbl[9]  = '{1'b0, 64'hFFFFFFFF_807FFFFF, 32'h004};
        tbl[10] = '{1'b0, 64'hFFFFFFFF_FFC00000, 32'h200};
        tbl[11] = '{1'b1, 64'h3FF0000000000000, 32'h040};
        tbl[12] = '{1'b1, 64'hFFF0000000000001, 32'h100};
        tbl[13] = '{1'b0, 64'hFFFFFFFF_00000000, 32'h010};
        tbl[14] = '{1'b1, 64'hC000000000000000, 32'h002};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_res", o_res, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", i_ready, 1);
        chk("rst_tag", o_tag, 0);
        chk("rst_snan", o_snan, 0);
        foreach (tbl[i]) begin
            cyc(1, tbl[i].fmt, tbl[i].opnd, 5'(i), 1, 0);
            chk("lat1_valid", o_valid, 0);
            cyc(0, 0, 0, 0, 1, 0);
            chk("vec_valid", o_valid, 1);
            chk("vec_res", o_res, tbl[i].res);
            chk("vec_snan", o_snan, tbl[i].res[8]);
            cyc(0, 0, 0, 0, 1, 0);
        end
        t = 1; acc = 0; outs = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 20 && outs < 5; k++) begin
            cyc(t <= 5, 0, tbl[0].opnd, 5'(t), k >= 4, 0);
            if (last_acc) begin t++; acc++; end
            if (last_out) begin outs++; last_k = k; if (first_k < 0) first_k = k; end
            if (k == 2 || k == 3) begin
                chk("bp_iready", last_irdy, 0);
                chk("bp_accepts", acc, 2);
            end
        end
        chk("bp_outs", outs, 5);
        chk("bp_contig", last_k - first_k, 4);
        cyc(1, 0, tbl[1].opnd, 7, 1, 0);
        cyc(1, 0, tbl[1].opnd, 8, 1, 0);
        cyc(1, 0, tbl[1].opnd, 9, 1, 1);
        chk("fl_iready", last_irdy, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 1, 0);
            chk("fl_quiet", o_valid, 0);
        end
        cyc(1, 1, tbl[4].opnd, 10, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("fl_t10_valid", o_valid, 1);
        chk("fl_t10_tag", o_tag, 10);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, tbl[0].opnd, 11, 1, 0);
        cyc(1, 0, tbl[0].opnd, 12, 1, 0);
        rst = 1'b1;
        #1;
        chk("mrst_valid", o_valid, 0);
        chk("mrst_res", o_res, 0);
        q.delete();
        prev_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mrst_ready", i_ready, 1);
        cyc(1, 1, tbl[5].opnd, 13, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("mrst_resume_valid", o_valid, 1);
        chk("mrst_resume_res", o_res, 32'h020);
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 800; k++) begin
            logic f = 1'($urandom % 2);
            cyc(($urandom % 4) != 0, f, rnd_op(f), 5'($urandom), ($urandom % 4) != 0, ($urandom % 40) == 0);
        end
        repeat (4) cyc(0, 0, 0, 0, 1, 0);
        chk("drain_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
